// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: valid/ready transmitter, mid-bit sampling receiver
// with parity/framing checks, start-glitch rejection and internal loopback.
module uart_core_param #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_en,
    input  logic                 rx_en,
    input  logic                 loopback,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          HAS_PAR   = (PARITY != 0);
    localparam logic          ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_done_q, tx_done_d;
    logic                 tx_line_q, tx_line_d;
    logic                 tx_bit_end;

    assign tx_ready   = (tx_state_q == S_IDLE) && tx_en;
    assign tx_busy    = (tx_state_q != S_IDLE);
    assign tx_done    = tx_done_q;
    assign txd        = loopback ? 1'b1 : tx_line_q;
    assign tx_bit_end = (tx_cnt_q == BIT_LAST);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_done_d  = 1'b0;
        if (tx_state_q != S_IDLE)
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
        unique case (tx_state_q)
            S_IDLE: if (tx_valid && tx_ready) begin
                tx_shift_d = tx_data;
                tx_par_d   = (^tx_data) ^ ODD_PAR;
                tx_cnt_d   = '0;
                tx_state_d = S_START;
            end
            S_START: if (tx_bit_end) begin
                tx_bit_d   = '0;
                tx_state_d = S_DATA;
            end
            S_DATA: if (tx_bit_end) begin
                tx_shift_d = tx_shift_q >> 1;
                if (tx_bit_q == DATA_LAST) begin
                    tx_bit_d   = '0;
                    tx_state_d = HAS_PAR ? S_PARITY : S_STOP;
                end else begin
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end
            S_PARITY: if (tx_bit_end) begin
                tx_bit_d   = '0;
                tx_state_d = S_STOP;
            end
            S_STOP: if (tx_bit_end) begin
                if (tx_bit_q == STOP_LAST) begin
                    tx_state_d = S_IDLE;
                    tx_done_d  = 1'b1;
                end else begin
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        // Line level is registered from the next state so txd never glitches.
        unique case (tx_state_d)
            S_START:  tx_line_d = 1'b0;
            S_DATA:   tx_line_d = tx_shift_d[0];
            S_PARITY: tx_line_d = tx_par_d;
            default:  tx_line_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_done_q  <= tx_done_d;
            tx_line_q  <= tx_line_d;
        end
    end

    state_t               rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_par_bit_q, rx_par_bit_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic [1:0]           rx_sync_q, rx_sync_d;
    logic                 rx_prev_q;
    logic                 rx_line, rx_bit_end;

    assign rx_line       = rx_sync_q[1];
    assign rx_bit_end    = (rx_cnt_q == BIT_LAST);
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_busy       = (rx_state_q != S_IDLE);
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;

    always_comb begin
        rx_sync_d    = {rx_sync_q[0], loopback ? tx_line_q : rxd};
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_par_bit_d = rx_par_bit_q;
        rx_data_d    = rx_data_q;
        rx_perr_d    = rx_perr_q;
        rx_ferr_d    = rx_ferr_q;
        rx_valid_d   = 1'b0;
        if (rx_state_q != S_IDLE && !rx_en) begin
            rx_state_d = S_IDLE;
            rx_cnt_d   = '0;
        end else begin
            if (rx_state_q != S_IDLE)
                rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + CW'(1);
            unique case (rx_state_q)
                S_IDLE: if (rx_en && rx_prev_q && !rx_line) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_START;
                end
                // Half a bit in: a high line means the falling edge was a glitch.
                S_START: if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_line ? S_IDLE : S_DATA;
                end
                S_DATA: if (rx_bit_end) begin
                    rx_shift_d = {rx_line, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DATA_LAST)
                        rx_state_d = HAS_PAR ? S_PARITY : S_STOP;
                    else
                        rx_bit_d = rx_bit_q + 4'd1;
                end
                S_PARITY: if (rx_bit_end) begin
                    rx_par_bit_d = rx_line;
                    rx_state_d   = S_STOP;
                end
                S_STOP: if (rx_bit_end) begin
                    rx_data_d  = rx_shift_q;
                    rx_perr_d  = HAS_PAR & ((^rx_shift_q) ^ rx_par_bit_q ^ ODD_PAR);
                    rx_ferr_d  = ~rx_line;
                    rx_valid_d = 1'b1;
                    rx_state_d = S_IDLE;
                end
                default: rx_state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: the two-flop synchroniser and edge history reset to idle-high so reset never fakes a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q   <= S_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_bit_q <= 1'b0;
            rx_data_q    <= '0;
            rx_perr_q    <= 1'b0;
            rx_ferr_q    <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_sync_q    <= 2'b11;
            rx_prev_q    <= 1'b1;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_bit_q <= rx_par_bit_d;
            rx_data_q    <= rx_data_d;
            rx_perr_q    <= rx_perr_d;
            rx_ferr_q    <= rx_ferr_d;
            rx_valid_q   <= rx_valid_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_line;
        end
    end
endmodule

// File: tb/tb_uart_core_param.sv
// Scoreboard bench for uart_core_param: 10 clk/bit, 8 data bits, even parity, 1 stop bit.
module tb_uart_core_param;
    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DB       = 8;
    localparam int PAR      = 1;
    localparam int SB       = 1;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int LATENCY  = (1 + DB + 1 + SB) * CPB + 1;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          perr;
        logic          ferr;
    } rx_exp_t;

    logic          clk, reset, tx_en, rx_en, loopback;
    logic [DB-1:0] tx_data;
    logic          tx_valid, tx_ready, tx_busy, tx_done, txd, rxd;
    logic [DB-1:0] rx_data;
    logic          rx_valid, rx_busy, rx_parity_err, rx_frame_err;

    uart_core_param #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB)
    ) dut (
        .clk(clk), .reset(reset), .tx_en(tx_en), .rx_en(rx_en), .loopback(loopback),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
        .tx_done(tx_done), .txd(txd), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_busy(rx_busy), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      total = 0;
    int      bad   = 0;
    int      cyc   = 0;
    int      acc_cyc = 0;
    int      txd_bad = 0;
    int      b2b_hits = 0;
    int      rx_cnt = 0;
    int      pushed = 0;
    rx_exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: latency, back-to-back accepts, loopback line level and scoreboard pops.
    always @(negedge clk) begin
        rx_exp_t e;
        if (!reset) begin
            if (loopback && txd !== 1'b1) txd_bad++;
            if (tx_done) begin
                check("tx_latency", cyc - acc_cyc, LATENCY);
                if (tx_valid && tx_ready) b2b_hits++;
            end
            if (tx_valid && tx_ready) acc_cyc = cyc;
            if (rx_valid) begin
                rx_cnt++;
                check("rx_sb_nonempty", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("rx_data", rx_data, e.data);
                    check("rx_parity_err", rx_parity_err, e.perr);
                    check("rx_frame_err", rx_frame_err, e.ferr);
                end
            end
        end
    end

    task automatic push_exp(input logic [DB-1:0] d, input logic pe, input logic fe);
        sb.push_back('{data: d, perr: pe, ferr: fe});
        pushed++;
    endtask

    task automatic wait_accept(input string tag);
        int ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1;
                break;
            end
        end
        check(tag, ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DB-1:0] d, input bit expect_rx);
        if (expect_rx) push_exp(d, 1'b0, 1'b0);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_accept("tx_accept_timeout");
        tx_valid = 1'b0;
    endtask

    task automatic hold_bit(input logic v);
        rxd = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [DB-1:0] d, input logic pbit, input logic stop);
        push_exp(d, (^d) ^ pbit, ~stop);
        @(posedge clk);
        #1;
        hold_bit(1'b0);
        for (int i = 0; i < DB; i++) hold_bit(d[i]);
        hold_bit(pbit);
        hold_bit(stop);
        rxd = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic wait_tx_idle(input string tag);
        int ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!tx_busy) begin
                ok = 1;
                break;
            end
        end
        check(tag, ok, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [DB-1:0] seq [4];
        int snap, seen, cleared, len;
        seq = '{8'h55, 8'hAA, 8'hF0, 8'h0F};

        reset = 1'b1; tx_en = 1'b0; rx_en = 1'b0; loopback = 1'b0;
        tx_valid = 1'b0; tx_data = '0; rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", txd, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_busy", rx_busy, 0);
        check("rst_rx_perr", rx_parity_err, 0);
        check("rst_rx_ferr", rx_frame_err, 0);
        check("rst_rx_data", rx_data, 0);
        check("ready_tx_en_low", tx_ready, 0);
        reset = 1'b0; tx_en = 1'b1; rx_en = 1'b1;
        @(posedge clk);
        #1;
        check("ready_idle", tx_ready, 1);

        // Single loopback frame with parity probe mid parity bit.
        loopback = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(8'hA5, 1'b1);
        repeat (94) @(posedge clk);
        @(negedge clk);
        check("tx_parity_bit", dut.tx_line_q, 0);
        wait_drain("drain_a5", 200);
        wait_tx_idle("tx_idle_a5");
        check("txd_high_loopback", txd_bad, 0);

        // Back-to-back frames with tx_valid held.
        snap = b2b_hits;
        tx_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tx_data = seq[k];
            push_exp(seq[k], 1'b0, 1'b0);
            wait_accept("b2b_accept_timeout");
        end
        tx_valid = 1'b0;
        wait_drain("drain_b2b", 600);
        wait_tx_idle("tx_idle_b2b");
        check("b2b_accepts", b2b_hits - snap, 3);

        // Externally driven frames: parity error, then framing error.
        loopback = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        drive_frame(8'h3C, 1'b1, 1'b1);
        wait_drain("drain_perr", 50);
        check("perr_flag", rx_parity_err, 1);
        check("perr_data", rx_data, 8'h3C);
        check("perr_ferr", rx_frame_err, 0);
        drive_frame(8'h81, 1'b0, 1'b0);
        wait_drain("drain_ferr", 50);
        check("ferr_flag", rx_frame_err, 1);
        check("ferr_data", rx_data, 8'h81);
        check("ferr_perr", rx_parity_err, 0);

        // Start-bit glitch: 3 low cycles.
        snap = rx_cnt; seen = 0; cleared = 0; len = 0;
        @(posedge clk);
        #1;
        rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rxd = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rx_busy) begin
                seen = 1;
                len++;
            end else if (seen) begin
                cleared = 1;
            end
        end
        check("glitch_busy_seen", seen, 1);
        check("glitch_busy_clear", cleared, 1);
        check("glitch_busy_len", len, CPB / 2);
        check("glitch_no_valid", rx_cnt - snap, 0);

        // Reset 40 cycles into a loopback frame, then a clean frame.
        loopback = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(8'h3C, 1'b0);
        repeat (39) @(posedge clk);
        #1;
        check("pre_rst_tx_busy", tx_busy, 1);
        check("pre_rst_rx_busy", rx_busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_txd", dut.tx_line_q, 1);
        check("mid_rst_tx_busy", tx_busy, 0);
        check("mid_rst_tx_done", tx_done, 0);
        check("mid_rst_rx_busy", rx_busy, 0);
        check("mid_rst_rx_valid", rx_valid, 0);
        check("mid_rst_rx_perr", rx_parity_err, 0);
        check("mid_rst_rx_ferr", rx_frame_err, 0);
        check("mid_rst_rx_data", rx_data, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        snap = rx_cnt;
        send(8'h3C, 1'b1);
        wait_drain("drain_post_rst", 300);
        wait_tx_idle("tx_idle_post_rst");
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_rx_count", rx_cnt - snap, 1);
        check("post_rst_rx_data", rx_data, 8'h3C);
        check("rx_total", rx_cnt, pushed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
- Parametrised full-duplex UART core; successor to the fixed 8N1 transmit/receive pair.
- Configurable data width, parity mode and stop-bit count, with valid/ready transmit handshake.
- Receiver detects parity and framing errors and rejects start-bit glitches.
- Internal loopback mode lets the pair be self-tested without external wiring.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer division, must be >= 4.
- DATA_BITS, 8: payload width, legal range 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of transmitted stop bits, 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- tx_en  in  1  transmitter enable.
- rx_en  in  1  receiver enable.
- loopback  in  1  when 1, the receiver input is the internal tx line and txd is held at 1.
- tx_data  in  DATA_BITS  payload to send.
- tx_valid  in  1  payload offered.
- tx_ready  out  1  core accepts payload this cycle.
- tx_busy  out  1  frame in progress.
- tx_done  out  1  one-cycle pulse at end of frame.
- txd  out  1  serial output, idle high.
- rxd  in  1  serial input, asynchronous to clk.
- rx_data  out  DATA_BITS  last received payload.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- rx_busy  out  1  receive frame in progress.
- rx_parity_err  out  1  parity mismatch on last frame.
- rx_frame_err  out  1  stop bit sampled low on last frame.

Behaviour:
- Reset values:
  - txd = 1; tx_busy, tx_done, rx_valid, rx_busy, rx_parity_err, rx_frame_err = 0; rx_data = 0.
  - Both state machines go to IDLE and all counters clear.
  - Reset may be asserted mid-frame; this aborts the frame immediately with no done or valid pulse.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped when PARITY = 0) -> STOP -> IDLE.
- tx_ready = (TX state == IDLE) && tx_en, decoded from registered state.
- Accept occurs when tx_valid && tx_ready:
  - tx_data is latched.
  - On the next cycle txd = 0 and tx_busy = 1.
- Each bit is held for exactly CLKS_PER_BIT cycles. Data is sent LSB first.
- Parity bit:
  - Even mode: XOR of the data bits.
  - Odd mode: inverted XOR of the data bits.
- STOP holds txd = 1 for STOP_BITS*CLKS_PER_BIT cycles.
- tx_done pulses for 1 cycle in the first IDLE cycle after the frame; tx_busy = 0 in that same cycle and tx_ready may be 1.
- Accept-to-tx_done latency is (1 + DATA_BITS + (PARITY != 0) + STOP_BITS)*CLKS_PER_BIT + 1 cycles.
- Back-to-back frames: if tx_valid is held, the next accept happens in the tx_done cycle, leaving no extra idle bit.
- tx_en deasserted mid-frame: the current frame completes; no new accept occurs.
- RX synchronisation: the selected input (rxd, or the internal tx line in loopback) passes through a 2-flop synchroniser.
- RX FSM: IDLE -> START -> DATA -> PARITY (skipped when PARITY = 0) -> STOP -> IDLE.
- IDLE -> START on a synchronised falling edge while rx_en = 1; rx_busy = 1 from that point.
- START samples at CLKS_PER_BIT/2:
  - If the line is high, the start is a glitch: return to IDLE, rx_busy = 0, no pulse.
  - Otherwise continue.
- Subsequent bits are sampled every CLKS_PER_BIT cycles, at mid-bit.
- STOP:
  - Only the first stop bit is sampled, allowing back-to-back frames from a 2-stop transmitter.
  - After that sample, in the same cycle, the block updates rx_data, rx_parity_err (0 if PARITY = 0) and rx_frame_err (1 if the stop bit is low), pulses rx_valid, and returns to IDLE.
- rx_data and both error flags hold until the next rx_valid; they are updated even on error.
- rx_en deasserted mid-frame: return to IDLE on the next cycle, rx_busy = 0, no rx_valid, outputs unchanged.
- Changing loopback mid-frame is undefined. Benches must change it only with both FSMs idle.
- For DATA_BITS = 9, all 9 bits are carried; no address-mode semantics.

Test Plan (CLK_FREQ = 1_000_000, BAUD_RATE = 100_000, giving 10 clk/bit; DATA_BITS = 8, PARITY = 1, STOP_BITS = 1, unless noted):
- Loopback = 1, send 0xA5:
  - txd stays 1 throughout.
  - Internal parity bit = 0.
  - tx_done occurs 111 cycles after accept.
  - rx_valid = 1 with rx_data = 0xA5 and both error flags 0.
- Loopback = 1, tx_valid held with 0x55, 0xAA, 0xF0, 0x0F in sequence:
  - Each accept coincides with the previous tx_done.
  - Four rx_valid pulses, in order, with no errors.
- Loopback = 0, bench drives rxd with 0x3C and parity bit 1 -> rx_parity_err = 1, rx_data = 0x3C, rx_frame_err = 0.
- Loopback = 0, bench drives 0x81 with correct parity and stop bit 0 -> rx_frame_err = 1, rx_data = 0x81.
- rxd pulled low for 3 cycles then high -> rx_busy returns to 0 at the mid-start sample; no rx_valid.
- Reset asserted 40 cycles into a frame -> txd = 1 and all flags 0 immediately. A fresh 0x3C frame after release is received correctly, with no stale pulse.
